coin_dispenser: RTL and testbench
=================================

COIN_DISPENSER -- requirements
Module: coin_dispenser

Interface
REQ-001 SHALL have parameter NUM_COINS, default 3, number of coin denominations.
REQ-002 SHALL have parameter TOTAL_BITS, default 31, width of money values.
REQ-003 SHALL have parameters COIN_VAL_0/1/2, defaults 100/500/1000, value of coin index 0/1/2 (ascending).
REQ-004 SHALL have parameter STOCK_BITS, default 8, width of each per-coin stock counter.
REQ-005 SHALL have parameter INIT_STOCK, default 8, stock loaded per coin at reset.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, hopper wait limit (used only under DISPENSE_TIMEOUT_EN).
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_return_req  in  1  one-cycle request to return i_return_amount.
- i_return_amount  in  TOTAL_BITS  amount to dispense; sampled with i_return_req.
- i_refill  in  NUM_COINS  one-hot-or-multi; +1 stock per asserted bit per cycle.
- i_coin_ready  in  1  hopper accepts current coin.
- o_coin_valid  out  1  coin offered to hopper.
- o_coin_sel  out  NUM_COINS  one-hot coin index offered; zero when o_coin_valid=0.
- o_busy  out  1  request in progress (state != IDLE).
- o_done  out  1  one-cycle completion pulse.
- o_returned_total  out  TOTAL_BITS  sum dispensed for current/last request.
- o_shortfall  out  TOTAL_BITS  undispensed remainder, valid from o_done.
- o_empty  out  NUM_COINS  bit k high when stock[k]==0.
- o_fault  out  1  one-cycle hopper-timeout pulse.

Function
REQ-008 SHALL implement FSM IDLE, SELECT, DISPENSE, DONE.
REQ-009 IDLE: on i_return_req SHALL latch amount into remaining, clear o_returned_total, go SELECT; o_busy high next cycle.
REQ-010 i_return_req outside IDLE SHALL be ignored with no state change.
REQ-011 SELECT: SHALL pick highest k with COIN_VAL_k <= remaining and stock[k] > 0, drive o_coin_sel one-hot k, o_coin_valid=1, go DISPENSE; if none, go DONE.
REQ-012 Request at edge N SHALL yield first o_coin_valid at edge N+2.
REQ-013 DISPENSE: o_coin_valid and o_coin_sel SHALL stay stable until i_coin_ready=1.
REQ-014 On valid&&ready SHALL: remaining -= COIN_VAL_k, stock[k] -= 1, o_returned_total += COIN_VAL_k, drop valid, go SELECT.
REQ-015 DONE: o_done=1 for exactly one cycle, o_shortfall=remaining, go IDLE; o_shortfall and o_returned_total hold until next accepted request.
REQ-016 Zero amount SHALL pass SELECT->DONE with no coin offered.
REQ-017 Refill SHALL saturate at 2^STOCK_BITS-1; refill and dispense of the same coin in one cycle SHALL net zero change.
REQ-018 Stock SHALL never underflow; o_empty is combinational from stock.
REQ-019 All subtractions SHALL be unsigned; remaining never negative by construction of REQ-011.

Reset
REQ-020 Reset SHALL act immediately, regardless of clk: state IDLE, all outputs 0, remaining 0, stock[k]=INIT_STOCK, timeout counter 0.
REQ-021 Reset mid-DISPENSE SHALL drop o_coin_valid at once with no stock decrement and no o_done.

Configuration
REQ-022 With DISPENSE_TIMEOUT_EN defined, SHALL count DISPENSE cycles without ready; at TIMEOUT_CYCLES SHALL drop valid, pulse o_fault one cycle, go DONE with shortfall=remaining.
REQ-023 Without DISPENSE_TIMEOUT_EN, SHALL wait in DISPENSE indefinitely; o_fault tied 0; no counter logic.

Verification
REQ-024 Amount 1600, stock 8 each, ready=1 -> coins 1000,500,100; returned 1600; shortfall 0; one o_done.
REQ-025 Amount 1700, stock[2]=0 -> 500,500,500,100,100; returned 1700; o_empty=3'b100 throughout.
REQ-026 Amount 250 -> 100,100; shortfall 50; returned 200.
REQ-027 Ready held low 5 cycles on first coin -> valid/sel stable 5 cycles, single decrement on accept; i_return_req during busy ignored.
REQ-028 Reset asserted mid-DISPENSE -> valid low without waiting for clk, stock back to 8, no o_done.
REQ-029 With DISPENSE_TIMEOUT_EN, amount 500, ready=0 -> o_fault at 16th waiting cycle, o_done next, shortfall 500.

Source files
------------

// File: rtl/coin_dispenser.sv
// coin_dispenser: returns a requested amount of money as a sequence of coins,
// always offering the largest in-stock coin that still fits the remainder.
// Keeps a saturating stock counter per coin and reports any amount it could
// not pay out.
//
// Optional feature macro: DISPENSE_TIMEOUT_EN
//   defined   : a coin offer that the hopper has not taken after TIMEOUT_CYCLES
//               cycles is withdrawn, o_fault pulses and the request ends with
//               the unpaid remainder as shortfall.
//   undefined : the dispenser waits on the hopper indefinitely, o_fault = 0.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   i_return_req      one-cycle request (accepted only while idle)
//   i_return_amount   amount to return, sampled with i_return_req
//   i_refill          +1 stock for each asserted bit, every cycle
//   i_coin_ready      hopper takes the coin currently offered
//   o_coin_valid      a coin is being offered to the hopper
//   o_coin_sel        one-hot index of the offered coin (0 when not valid)
//   o_busy            a request is in progress
//   o_done            one-cycle pulse at the end of a request
//   o_returned_total  amount paid out for the current/last request
//   o_shortfall       unpaid remainder of the last request
//   o_empty           bit k set while coin k is out of stock
//   o_fault           one-cycle hopper timeout pulse
module coin_dispenser #(
  parameter int NUM_COINS      = 3,
  parameter int TOTAL_BITS     = 31,
  parameter int COIN_VAL_0     = 100,
  parameter int COIN_VAL_1     = 500,
  parameter int COIN_VAL_2     = 1000,
  parameter int STOCK_BITS     = 8,
  parameter int INIT_STOCK     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_return_req,
  input  logic [TOTAL_BITS-1:0] i_return_amount,
  input  logic [NUM_COINS-1:0]  i_refill,
  input  logic                  i_coin_ready,
  output logic                  o_coin_valid,
  output logic [NUM_COINS-1:0]  o_coin_sel,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_returned_total,
  output logic [TOTAL_BITS-1:0] o_shortfall,
  output logic [NUM_COINS-1:0]  o_empty,
  output logic                  o_fault
);

  typedef enum logic [1:0] {IDLE, SELECT, DISPENSE, DONE} state_t;

  localparam logic [STOCK_BITS-1:0] STOCK_MAX = '1;

  function automatic logic [TOTAL_BITS-1:0] coin_val(input int k);
    case (k)
      0:       coin_val = TOTAL_BITS'(COIN_VAL_0);
      1:       coin_val = TOTAL_BITS'(COIN_VAL_1);
      default: coin_val = TOTAL_BITS'(COIN_VAL_2);
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [TOTAL_BITS-1:0]   remaining_q, remaining_d;
  logic [TOTAL_BITS-1:0]   total_q, total_d;
  logic [TOTAL_BITS-1:0]   shortfall_q, shortfall_d;
  logic [NUM_COINS-1:0]    sel_q, sel_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [STOCK_BITS-1:0]   stock_q [NUM_COINS];
  logic [STOCK_BITS-1:0]   stock_d [NUM_COINS];

  logic [NUM_COINS-1:0]    pick_oh;
  logic                    pick_found;
  logic [TOTAL_BITS-1:0]   sel_val;
  logic                    accept;
  logic                    timeout_hit;

  assign accept = valid_q & i_coin_ready;

  // Ascending scan: the last coin that fits and is stocked wins, i.e. the highest.
  always_comb begin
    pick_oh    = '0;
    pick_found = 1'b0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (coin_val(k) <= remaining_q && stock_q[k] != '0) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_val = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (sel_q[k]) sel_val = sel_val | coin_val(k);
    end
  end

`ifdef DISPENSE_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;

  // The wait counter holds the number of completed idle-hopper cycles; the
  // offer is abandoned at the edge that ends the TIMEOUT_CYCLES-th one.
  assign timeout_hit = (state_q == DISPENSE) && !i_coin_ready &&
                       (wait_cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == DISPENSE && !i_coin_ready && !timeout_hit)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_cnt_q <= '0;
    else       wait_cnt_q <= wait_cnt_d;
  end

  assign o_fault = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT_CYCLES only matters in timeout builds; the term is constant zero.
  assign o_fault = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    shortfall_d = shortfall_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_return_req) begin
          remaining_d = i_return_amount;
          total_d     = '0;
          shortfall_d = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (pick_found) begin
          sel_d   = pick_oh;
          valid_d = 1'b1;
          state_d = DISPENSE;
        end else begin
          shortfall_d = remaining_q;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DISPENSE: begin
        if (accept) begin
          // Selected coin never exceeds remaining, so this cannot wrap.
          remaining_d = remaining_q - sel_val;
          total_d     = total_q + sel_val;
          valid_d     = 1'b0;
          sel_d       = '0;
          state_d     = SELECT;
        end else if (timeout_hit) begin
          valid_d     = 1'b0;
          sel_d       = '0;
          shortfall_d = remaining_q;
          done_d      = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A refill and a dispense of the same coin in one cycle cancel out.
  always_comb begin
    for (int k = 0; k < NUM_COINS; k++) begin
      stock_d[k] = stock_q[k];
      if (accept && sel_q[k] && !i_refill[k])
        stock_d[k] = stock_q[k] - 1'b1;
      else if (!(accept && sel_q[k]) && i_refill[k] && stock_q[k] != STOCK_MAX)
        stock_d[k] = stock_q[k] + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      total_q     <= '0;
      shortfall_q <= '0;
      sel_q       <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < NUM_COINS; k++) stock_q[k] <= STOCK_BITS'(INIT_STOCK);
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      shortfall_q <= shortfall_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      for (int k = 0; k < NUM_COINS; k++) stock_q[k] <= stock_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_COINS; k++) o_empty[k] = (stock_q[k] == '0);
  end

  assign o_coin_valid     = valid_q;
  assign o_coin_sel       = sel_q;
  assign o_busy           = (state_q != IDLE);
  assign o_done           = done_q;
  assign o_returned_total = total_q;
  assign o_shortfall      = shortfall_q;

endmodule

// File: tb/tb_coin_dispenser.sv
module tb_coin_dispenser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_return_req = 1'b0;
  logic [30:0] i_return_amount = '0;
  logic [2:0]  i_refill = '0;
  logic        i_coin_ready = 1'b0;
  logic        o_coin_valid;
  logic [2:0]  o_coin_sel;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_returned_total;
  logic [30:0] o_shortfall;
  logic [2:0]  o_empty;
  logic        o_fault;

  int checks = 0;
  int errors = 0;

  // Reference model: coin values and stock as plain integers.
  int vals [3] = '{100, 500, 1000};
  int ms   [3];

  coin_dispenser dut (
    .clk(clk), .reset(reset),
    .i_return_req(i_return_req), .i_return_amount(i_return_amount),
    .i_refill(i_refill), .i_coin_ready(i_coin_ready),
    .o_coin_valid(o_coin_valid), .o_coin_sel(o_coin_sel),
    .o_busy(o_busy), .o_done(o_done),
    .o_returned_total(o_returned_total), .o_shortfall(o_shortfall),
    .o_empty(o_empty), .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [2:0] s);
    if (s[2]) return 2;
    if (s[1]) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] model_empty();
    logic [2:0] e;
    for (int k = 0; k < 3; k++) e[k] = (ms[k] == 0);
    return e;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    i_return_req = 1'b0; i_refill = '0; i_coin_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) ms[k] = 8;
    tick();
  endtask

  task automatic refill_idle(input logic [2:0] mask, input int n);
    i_refill = mask;
    for (int c = 0; c < n; c++) begin
      tick();
      for (int k = 0; k < 3; k++) if (mask[k] && ms[k] < 255) ms[k]++;
    end
    i_refill = '0;
  endtask

  // One request end to end. Coins in refill_mask get a refill pulse on the
  // very cycle they are accepted (net-zero stock change).
  task automatic run_request(input int amount, input int ready_pct,
                             input int stall_first, input logic [2:0] refill_mask);
    int exp_q[$];
    int got_q[$];
    int rem, exp_total, cycles, stall_left, low_run;
    bit done_seen, ready, seq_ok;
    logic prev_valid, prev_ready;
    logic [2:0] prev_sel;

    rem = amount; exp_total = 0;
    for (int k = 2; k >= 0; k--) begin
      while (vals[k] <= rem && ms[k] > 0) begin
        exp_q.push_back(k);
        rem -= vals[k];
        exp_total += vals[k];
        if (!refill_mask[k]) ms[k]--;
      end
    end

    i_return_req = 1'b1; i_return_amount = 31'(amount); i_coin_ready = 1'b0;
    tick();
    i_return_req = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_coin_valid !== 1'b0 || o_returned_total !== 31'd0) begin
      errors++;
      $display("FAIL accept amt=%0d: busy=%b valid=%b total=%0d required busy=1 valid=0 total=0",
               amount, o_busy, o_coin_valid, o_returned_total);
    end

    cycles = 0; done_seen = 0; prev_valid = 0; prev_ready = 0; prev_sel = '0;
    stall_left = stall_first; low_run = 0;
    while (cycles < 4000) begin
      if (cycles == 1) begin
        checks++;
        if (o_coin_valid !== (exp_q.size() != 0) || o_done !== (exp_q.size() == 0)) begin
          errors++;
          $display("FAIL latency amt=%0d: valid=%b done=%b required valid=%b done=%b",
                   amount, o_coin_valid, o_done, exp_q.size() != 0, exp_q.size() == 0);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (o_coin_valid !== 1'b1 || o_coin_sel !== prev_sel) begin
          errors++;
          $display("FAIL hold amt=%0d: valid=%b sel=%b required valid=1 sel=%b",
                   amount, o_coin_valid, o_coin_sel, prev_sel);
        end
      end
      checks++;
      if (o_coin_valid ? !$onehot(o_coin_sel) : (o_coin_sel !== 3'b000)) begin
        errors++;
        $display("FAIL sel_shape amt=%0d: valid=%b sel=%b required one-hot when valid else 000",
                 amount, o_coin_valid, o_coin_sel);
      end
      if (o_done === 1'b1) begin
        done_seen = 1;
        break;
      end
      checks++;
      if (o_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy amt=%0d: busy=%b required 1", amount, o_busy);
      end
      if (o_coin_valid && stall_left > 0) begin
        ready = 0;
        stall_left--;
        i_return_req = 1'b1;
        i_return_amount = 31'd100;
      end else begin
        i_return_req = 1'b0;
        ready = (low_run >= 8) || ($urandom_range(0, 99) < ready_pct);
      end
      low_run = ready ? 0 : low_run + 1;
      i_coin_ready = ready;
      i_refill = (o_coin_valid && ready) ? (o_coin_sel & refill_mask) : 3'b000;
      if (o_coin_valid && ready) got_q.push_back(oh_idx(o_coin_sel));
      prev_valid = o_coin_valid; prev_sel = o_coin_sel; prev_ready = ready;
      tick();
      cycles++;
    end
    i_return_req = 1'b0; i_coin_ready = 1'b0; i_refill = '0;

    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout amt=%0d: no o_done within %0d cycles, required o_done", amount, cycles);
      return;
    end

    seq_ok = (got_q.size() == exp_q.size());
    if (seq_ok) foreach (exp_q[i]) if (got_q[i] != exp_q[i]) seq_ok = 0;
    if (!seq_ok) begin
      errors++;
      $display("FAIL coin_seq amt=%0d: got %0d coins %p required %0d coins %p",
               amount, got_q.size(), got_q, exp_q.size(), exp_q);
    end
    checks++;
    if (o_returned_total !== 31'(exp_total)) begin
      errors++;
      $display("FAIL returned amt=%0d: got %0d required %0d", amount, o_returned_total, exp_total);
    end
    checks++;
    if (o_shortfall !== 31'(amount - exp_total)) begin
      errors++;
      $display("FAIL shortfall amt=%0d: got %0d required %0d", amount, o_shortfall, amount - exp_total);
    end
    checks++;
    if (o_empty !== model_empty()) begin
      errors++;
      $display("FAIL empty amt=%0d: got %b required %b", amount, o_empty, model_empty());
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_returned_total !== 31'(exp_total) ||
        o_shortfall !== 31'(amount - exp_total)) begin
      errors++;
      $display("FAIL after_done amt=%0d: done=%b busy=%b total=%0d short=%0d required 0 0 %0d %0d",
               amount, o_done, o_busy, o_returned_total, o_shortfall, exp_total, amount - exp_total);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_coin_valid !== 1'b0 || o_coin_sel !== 3'b000 || o_busy !== 1'b0 || o_done !== 1'b0 ||
        o_returned_total !== 31'd0 || o_shortfall !== 31'd0 || o_empty !== 3'b000 || o_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b sel=%b busy=%b done=%b total=%0d short=%0d empty=%b fault=%b required all 0",
               o_coin_valid, o_coin_sel, o_busy, o_done, o_returned_total, o_shortfall, o_empty, o_fault);
    end
  endtask

  task automatic test_spec_vectors();
    run_request(1600, 100, 0, 3'b000);
    run_request(7000, 100, 0, 3'b000);
    checks++;
    if (o_empty !== 3'b100) begin
      errors++;
      $display("FAIL empty_pre_1700: got %b required 100", o_empty);
    end
    run_request(1700, 100, 0, 3'b000);
    run_request(250, 100, 0, 3'b000);
  endtask

  task automatic test_stall();
    refill_idle(3'b111, 3);
    run_request(1600, 100, 5, 3'b000);
  endtask

  task automatic test_zero();
    run_request(0, 100, 0, 3'b000);
  endtask

  task automatic test_reset_mid_dispense();
    i_return_req = 1'b1; i_return_amount = 31'd500; i_coin_ready = 1'b0;
    tick();
    i_return_req = 1'b0;
    tick(); tick();
    checks++;
    if (o_coin_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: valid=%b required 1", o_coin_valid);
    end
    i_coin_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (o_coin_valid !== 1'b0 || o_busy !== 1'b0 || o_coin_sel !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: valid=%b busy=%b sel=%b required 0 0 000",
               o_coin_valid, o_busy, o_coin_sel);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_empty !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_done: done=%b empty=%b required 0 000", o_done, o_empty);
    end
    i_coin_ready = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) ms[k] = 8;
    tick();
    run_request(8000, 100, 0, 3'b000);
  endtask

  task automatic test_net_zero();
    refill_idle(3'b100, 8);
    run_request(9000, 100, 0, 3'b100);
  endtask

  task automatic test_saturation();
    do_reset();
    refill_idle(3'b001, 300);
    run_request(42000, 100, 0, 3'b000);
  endtask

  task automatic test_random();
    logic [2:0] mask;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 1) == 1) refill_idle(3'($urandom_range(0, 7)), $urandom_range(1, 20));
      mask = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      run_request($urandom_range(0, 80) * 50, $urandom_range(30, 100), $urandom_range(0, 3), mask);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_stall();
    test_zero();
    test_reset_mid_dispense();
    test_net_zero();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
